// File: rtl/des_align_pkg.sv
// Shared types and sizing helpers for the deserializer word aligner.
`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif

package des_align_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEARCH  = 2'd1,
      ST_CONFIRM = 2'd2,
      ST_LOCKED  = 2'd3
   } des_align_state_t;

   // Width that holds 0..max(confirm_n, loss_n) without wrapping.
   function automatic int cnt_width(input int confirm_n, input int loss_n);
      int m;
      m = (confirm_n > loss_n) ? confirm_n : loss_n;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/des_align_match.sv
// Compares every bit offset of {din, prev} against the training word and
// reports the lowest matching offset.
module des_align_match
   import des_align_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] TRAIN_PAT = WIDTH'(1)
) (
   input  logic [2*WIDTH-1:0]         cat,
   output logic                       hit,
   output logic [$clog2(WIDTH)-1:0]   idx
);

   logic [WIDTH-1:0] eq;

   for (genvar g = 0; g < WIDTH; g++) begin : g_cmp
      assign eq[g] = (cat[g +: WIDTH] == TRAIN_PAT);
   end

   // Walk high to low so the lowest matching offset is the one left standing.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int s = WIDTH - 1; s >= 0; s--) begin
         if (eq[s]) begin
            hit = 1'b1;
            idx = ($clog2(WIDTH))'(s);
         end
      end
   end

endmodule

// File: rtl/des_word_aligner.sv
// Word aligner: searches for the training word across all bit offsets,
// confirms it, then emits aligned payload. Optional err_cnt via DES_ALIGN_ERRCNT_EN.
`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif

module des_word_aligner
   import des_align_pkg::*;
#(
   parameter int               WIDTH     = 2**`SERDES_STAGES,
   parameter logic [WIDTH-1:0] TRAIN_PAT = WIDTH'(1),
   parameter int               CONFIRM_N = 4,
   parameter int               LOSS_N    = 4
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic [WIDTH-1:0]          din,
   input  logic                      train_en,
   input  logic                      realign,
   output logic [WIDTH-1:0]          dout,
   output logic                      dout_valid,
   output logic                      locked,
   output logic [$clog2(WIDTH)-1:0]  shift
`ifdef DES_ALIGN_ERRCNT_EN
   ,
   output logic [7:0]                err_cnt
`endif
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = cnt_width(CONFIRM_N, LOSS_N);
   localparam logic [CW-1:0] CONFIRM_LAST = CW'(CONFIRM_N - 1);
   localparam logic [CW-1:0] LOSS_LAST    = CW'(LOSS_N - 1);

   des_align_state_t   state_q, state_d;
   logic [WIDTH-1:0]   prev_q, prev_d, dout_q, dout_d;
   logic               dout_valid_q, dout_valid_d, locked_q, locked_d;
   logic [SW-1:0]      shift_q, shift_d;
   logic [CW-1:0]      cnt_q, cnt_d, miss_q, miss_d;

   logic [2*WIDTH-1:0] cat;
   logic [WIDTH-1:0]   aligned;
   logic               match, hit;
   logic [SW-1:0]      idx;

   assign cat     = {din, prev_q};
   assign aligned = cat[shift_q +: WIDTH];
   assign match   = (aligned == TRAIN_PAT);

   des_align_match #(
      .WIDTH     (WIDTH),
      .TRAIN_PAT (TRAIN_PAT)
   ) u_match (
      .cat (cat),
      .hit (hit),
      .idx (idx)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      miss_d  = miss_q;
      prev_d  = din;
      dout_d  = aligned;
      if (realign) begin
         state_d = ST_SEARCH;
         cnt_d   = '0;
         miss_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: if (train_en) state_d = ST_SEARCH;
            ST_SEARCH: begin
               if (!train_en) begin
                  state_d = ST_IDLE;
               end else if (hit) begin
                  shift_d = idx;
                  cnt_d   = CW'(1);
                  miss_d  = '0;
                  state_d = (CONFIRM_N <= 1) ? ST_LOCKED : ST_CONFIRM;
               end
            end
            ST_CONFIRM: begin
               if (!train_en) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (!match) begin
                  state_d = ST_SEARCH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q >= CONFIRM_LAST) begin
                     state_d = ST_LOCKED;
                     miss_d  = '0;
                  end
               end
            end
            ST_LOCKED: begin
               // Payload mode (train_en low) leaves the miss counter untouched.
               if (train_en) begin
                  if (match) begin
                     miss_d = '0;
                  end else if (miss_q >= LOSS_LAST) begin
                     state_d = ST_SEARCH;
                     miss_d  = '0;
                     cnt_d   = '0;
                  end else begin
                     miss_d = miss_q + CW'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      locked_d     = (state_d == ST_LOCKED);
      dout_valid_d = !realign && (state_q == ST_LOCKED) && !train_en;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q      <= ST_IDLE;
         prev_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         shift_q      <= '0;
         cnt_q        <= '0;
         miss_q       <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         locked_q     <= locked_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         miss_q       <= miss_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign locked     = locked_q;
   assign shift      = shift_q;

`ifdef DES_ALIGN_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (realign)
         err_cnt_d = '0;
      else if ((state_q == ST_LOCKED) && train_en && !match && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) err_cnt_q <= '0;
      else       err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/des_word_aligner.md
DES_WORD_ALIGNER -- requirements
Module: des_word_aligner

Interface
REQ-001 SHALL have parameter WIDTH, default 2**`SERDES_STAGES: bits per deserialized word.
REQ-002 SHALL have parameter TRAIN_PAT [WIDTH-1:0], default 1: training word; every rotation of it is distinct.
REQ-003 SHALL have parameter CONFIRM_N, default 4: consecutive matches needed to lock.
REQ-004 SHALL have parameter LOSS_N, default 4: consecutive mismatches needed to drop lock.
REQ-005 SHALL have port clk, input, 1 bit: the slowest deserializer clock; all logic is posedge.
REQ-006 SHALL have port rstb, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port din, input, WIDTH bits: raw parallel deserializer output, sampled every clk.
REQ-008 SHALL have port train_en, input, 1 bit: the link is sending TRAIN_PAT.
REQ-009 SHALL have port realign, input, 1 bit: single-cycle pulse that forces a new search.
REQ-010 SHALL have port dout, output, WIDTH bits: word-aligned payload.
REQ-011 SHALL have port dout_valid, output, 1 bit: dout holds payload.
REQ-012 SHALL have port locked, output, 1 bit: alignment is established.
REQ-013 SHALL have port shift, output, $clog2(WIDTH) bits: the selected bit offset.

Function
REQ-014 SHALL register the previous din as prev each cycle, forming cat = {din, prev}.
- Aligned word for offset s = cat[s +: WIDTH].
REQ-015 SHALL implement states IDLE, SEARCH, CONFIRM, LOCKED with the following transitions:
- IDLE -> SEARCH when train_en=1.
- SEARCH -> CONFIRM when any offset matches TRAIN_PAT; the lowest matching s is latched into shift and cnt=1.
- CONFIRM: a match at the latched shift increments cnt; LOCKED when cnt reaches CONFIRM_N; a mismatch returns to SEARCH with cnt=0.
- SEARCH or CONFIRM with train_en=0 -> IDLE.
- LOCKED with train_en=1: each mismatch increments a miss counter and each match clears it; LOSS_N consecutive mismatches -> SEARCH, with locked=0 on the next edge.
- LOCKED with train_en=0: payload mode; mismatches are not counted.
REQ-016 SHALL treat realign=1 as a move to SEARCH from any state, clearing all counters, locked and dout_valid; realign takes priority over every other transition.
REQ-017 SHALL register dout = cat[shift +: WIDTH] with a latency of exactly one clk from the din sample.
REQ-018 SHALL set dout_valid=1 only in LOCKED with train_en=0, aligned to the same sample as dout.
REQ-019 SHALL assert locked exactly while the state is LOCKED.
REQ-020 SHALL hold shift constant in CONFIRM and LOCKED; shift may update only on the SEARCH->CONFIRM transition.
REQ-021 SHALL keep cnt and the miss counter at $clog2(max(CONFIRM_N, LOSS_N)+1) bits each, with no wrap.

Reset
REQ-022 SHALL, when rstb=0, asynchronously force state=IDLE, prev=0, dout=0, dout_valid=0, locked=0, shift=0, all counters=0, and err_cnt=0 (if present).
REQ-023 SHALL, on reset assertion mid-LOCKED, drop locked and dout_valid without waiting for a clk edge.
REQ-024 SHALL leave IDLE on the first clk edge after rstb rises, if train_en=1.

Configuration
REQ-025 SHALL, when DES_ALIGN_ERRCNT_EN is defined, add output err_cnt [7:0]:
- Counts TRAIN_PAT mismatches seen in LOCKED with train_en=1.
- Saturates at 255.
- Cleared by reset and by realign.
REQ-026 SHALL, when DES_ALIGN_ERRCNT_EN is undefined, omit the err_cnt port and its logic; all other behaviour is identical.

Structure
REQ-027 SHALL place the des_align_state_t enum and the counter-width helper function in package des_align_pkg.
REQ-028 SHALL implement the all-offset comparator and lowest-index priority encoder as sub-module des_align_match, with inputs cat and TRAIN_PAT and outputs hit and idx.

Verification
All scenarios use WIDTH=4, TRAIN_PAT=4'b0001, CONFIRM_N=4, LOSS_N=4.
REQ-029 SHALL cover ideal alignment: train_en=1 with din=4'b0001 repeated -> shift=0; locked rises on the edge sampling the 4th matching word.
REQ-030 SHALL cover an offset of 2: train_en=1 with din=4'b0100 repeated -> shift=2; locked after 4 matches; then train_en=0 and din=4'b1000 followed by 4'b0010 -> dout=4'b1010 one clk later with dout_valid=1.
REQ-031 SHALL cover an early mismatch: in CONFIRM with cnt=2, inject din=4'b1111 -> state SEARCH, locked stays 0, and relock completes after 4 further good words.
REQ-032 SHALL cover loss of lock: in LOCKED with train_en=1, inject 3 bad words then 1 good word -> remains locked; inject 4 consecutive bad words -> locked=0 on the next edge.
REQ-033 SHALL cover reset mid-lock: drop rstb at an arbitrary time -> locked, dout_valid and dout go to 0 immediately; after release with train_en=1, the block relocks.
REQ-034 SHALL cover DES_ALIGN_ERRCNT_EN defined: 300 bad words in LOCKED with LOSS_N raised to 1000 -> err_cnt=255; realign pulse -> err_cnt=0 and state SEARCH.
